// File: rtl/serial_add_pkg.sv
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared types and constants for the bit-serial adder front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

    localparam int c_default_n = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_reg_n.sv
// ============================================================================
// Module      : shift_reg_n
// Description : N-bit right-shift register with parallel load and serial-in.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_n #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         shift_en,
    input  logic         ser_in,
    output logic [N-1:0] q
);

    logic [N-1:0] r_q;

    // Parallel load takes priority over shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= load_data;
        end else if (shift_en) begin
            r_q <= {ser_in, r_q[N-1:1]};
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module      : serial_add_ctrl
// Description : Parallel-to-serial driver and result collector for the
//               external bit-serial adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int N = c_default_n
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic         cin,
    output logic         ser_a,
    output logic         ser_b,
    output logic         ser_cin,
    output logic         ser_load,
    input  logic         ser_s,
    input  logic         ser_c,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int c_cnt_w = (N > 2) ? $clog2(N) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(N - 1);

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_ser_a;
    logic                 r_ser_b;
    logic                 r_ser_cin;
    logic                 r_ser_load;
    logic                 r_busy;
    logic                 r_done;
    logic [N-1:0]         r_sum;
    logic                 r_cout;

    logic                 w_accept;
    logic                 w_op_shift;
    logic                 w_res_shift;
    logic                 w_last;
    logic [N-1:0]         w_a_q;
    logic [N-1:0]         w_b_q;
    logic [N-1:0]         w_res_q;
    logic                 w_unused;

    assign w_accept    = (r_state == IDLE) && start;
    assign w_res_shift = (r_state == SHIFT);
    assign w_last      = w_res_shift && (r_cnt == c_last);
    // Operands start shifting in LOAD so that bit 0 always holds the next bit to send.
    assign w_op_shift  = (r_state == LOAD) || (r_state == SHIFT);

    shift_reg_n #(.N(N)) u_sr_a (
        .clk       (clk),
        .rst       (rst),
        .load      (w_accept),
        .load_data (a_in),
        .shift_en  (w_op_shift),
        .ser_in    (1'b0),
        .q         (w_a_q)
    );

    shift_reg_n #(.N(N)) u_sr_b (
        .clk       (clk),
        .rst       (rst),
        .load      (w_accept),
        .load_data (b_in),
        .shift_en  (w_op_shift),
        .ser_in    (1'b0),
        .q         (w_b_q)
    );

    shift_reg_n #(.N(N)) u_sr_res (
        .clk       (clk),
        .rst       (rst),
        .load      (w_accept),
        .load_data ({N{1'b0}}),
        .shift_en  (w_res_shift),
        .ser_in    (ser_s),
        .q         (w_res_q)
    );

    // Only the LSB of the operand registers leaves the block.
    assign w_unused = ^{w_a_q[N-1:1], w_b_q[N-1:1], w_res_q[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_ser_a    <= 1'b0;
            r_ser_b    <= 1'b0;
            r_ser_cin  <= 1'b0;
            r_ser_load <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state    <= LOAD;
                        r_busy     <= 1'b1;
                        r_ser_load <= 1'b1;
                        r_ser_cin  <= cin;
                        r_ser_a    <= 1'b0;
                        r_ser_b    <= 1'b0;
                    end
                end
                LOAD: begin
                    r_state    <= SHIFT;
                    r_cnt      <= '0;
                    r_ser_load <= 1'b0;
                    r_ser_cin  <= 1'b0;
                    r_ser_a    <= w_a_q[0];
                    r_ser_b    <= w_b_q[0];
                end
                SHIFT: begin
                    if (w_last) begin
                        r_state <= DONE;
                        r_sum   <= {ser_s, w_res_q[N-1:1]};
                        r_cout  <= ser_c;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_ser_a <= 1'b0;
                        r_ser_b <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_ser_a <= w_a_q[0];
                        r_ser_b <= w_b_q[0];
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ser_a    = r_ser_a;
    assign ser_b    = r_ser_b;
    assign ser_cin  = r_ser_cin;
    assign ser_load = r_ser_load;
    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Directed self-checking bench; models the bit-serial adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         cin;
    logic         ser_a;
    logic         ser_b;
    logic         ser_cin;
    logic         ser_load;
    logic         ser_s;
    logic         ser_c;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

    int errors = 0;
    int checks = 0;

    serial_add_ctrl #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin      (cin),
        .ser_a    (ser_a),
        .ser_b    (ser_b),
        .ser_cin  (ser_cin),
        .ser_load (ser_load),
        .ser_s    (ser_s),
        .ser_c    (ser_c),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout)
    );

    always #5 clk = ~clk;

    // Bit-serial adder cell: carry DFF loaded with cin, combinational sum/carry.
    logic cell_carry;
    always_ff @(posedge clk) begin
        if (rst)           cell_carry <= 1'b0;
        else if (ser_load) cell_carry <= ser_cin;
        else               cell_carry <= ser_c;
    end
    assign ser_s = ser_a ^ ser_b ^ cell_carry;
    assign ser_c = (ser_a & ser_b) | (cell_carry & (ser_a ^ ser_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full operation with cycle-exact checks; returns in the cycle after done.
    task automatic do_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic c, input logic [N-1:0] exp_sum, input logic exp_cout);
        a_in = a; b_in = b; cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_load"}, {29'd0, busy, ser_load, ser_cin}, {29'd0, 1'b1, 1'b1, c});
        for (int i = 0; i < N; i++) begin
            tick();
            chk({tag, "_shift"}, {28'd0, busy, done, ser_load, ser_a}, {28'd0, 3'b100, a[i]});
        end
        tick();
        chk({tag, "_done"}, {22'd0, busy, done, cout, sum}, {22'd0, 1'b0, 1'b1, exp_cout, exp_sum});
        tick();
        chk({tag, "_after"}, {22'd0, busy, done, cout, sum}, {22'd0, 1'b0, 1'b0, exp_cout, exp_sum});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
        tick();
        tick();
        chk("reset_outputs", {17'd0, busy, done, cout, ser_a, ser_b, ser_cin, ser_load, sum},
            32'd0);
        rst = 1'b0;
        tick();

        do_op("5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        do_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        do_op("ff_00_c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
        do_op("00_00_c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        do_op("a5_c3_c", 8'hA5, 8'hC3, 1'b1, 8'h69, 1'b1);

        // start held high; a_in changes mid-run
        a_in = 8'h11; b_in = 8'h22; cin = 1'b0; start = 1'b1;
        tick();
        tick();
        tick();
        a_in = 8'h40;
        for (int i = 0; i < 7; i++) tick();
        chk("held_first_done", {23'd0, done, cout, sum}, {23'd0, 1'b1, 1'b0, 8'h33});
        tick();
        chk("held_idle_gap", {30'd0, busy, done}, 32'd0);
        tick();
        chk("held_second_busy", {22'd0, busy, done, cout, sum}, {22'd0, 1'b1, 1'b0, 1'b0, 8'h33});
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("held_sum_kept", {23'd0, busy, cout, sum}, {23'd0, 1'b1, 1'b0, 8'h33});
        for (int i = 0; i < 4; i++) tick();
        chk("held_second_done", {23'd0, done, cout, sum}, {23'd0, 1'b1, 1'b0, 8'h62});
        tick();

        // reset during SHIFT at k=4
        a_in = 8'hAA; b_in = 8'h55; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_outputs", {17'd0, busy, done, cout, ser_a, ser_b, ser_cin, ser_load, sum},
            32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("midrst_no_done", {30'd0, busy, done}, 32'd0);
        end
        do_op("10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

        // rst and start together
        rst = 1'b1; start = 1'b1; a_in = 8'hFF; b_in = 8'hFF; cin = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", {30'd0, busy, ser_load}, 32'd0);
        tick();
        chk("rst_start_idle", {22'd0, busy, done, cout, sum}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
